// File: rtl/prod3_pkg.sv
// Shared types and constants for the prod3 hardwired responder.
package prod3_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_C,
        RD_W,
        MUL1,
        MUL2,
        WR_HI,
        WR_LO,
        DONE
    } state_t;

    localparam int W_DEF      = 8;
    localparam int AW_DEF     = 8;
    localparam int A_ADDR_DEF = 1;
    localparam int P_ADDR_DEF = 4;

    localparam int RUN_CYCLES = 2 * W_DEF + 6;

    localparam logic [15:0] CT_MAX = 16'hFFFF;

    function automatic logic counted_state(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/prod3_engine_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first.
// The start cycle already performs the first iteration, so a product takes W clocks.
module shift_add_mul #(
    parameter int W  = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clr,
    input  logic [PW-1:0] multiplicand,
    input  logic [W-1:0]  multiplier,
    output logic          busy,
    output logic [PW-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [PW-1:0] acc_reg, acc_next;
    logic [PW-1:0] mcand_reg, mcand_next;
    logic [W-1:0]  mplier_reg, mplier_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        if (clr) begin
            acc_next    = '0;
            mcand_next  = '0;
            mplier_next = '0;
            cnt_next    = '0;
        end else if (start) begin
            acc_next    = multiplier[0] ? multiplicand : '0;
            mcand_next  = multiplicand << 1;
            mplier_next = multiplier >> 1;
            cnt_next    = CW'(W - 1);
        end else if (cnt_reg != '0) begin
            // Accumulator wraps naturally at PW bits, giving the modulo product.
            acc_next    = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg - 1'b1;
        end
    end

    assign busy    = (cnt_reg != '0);
    assign product = acc_reg;

endmodule

// File: rtl/prod3_engine.sv
// Hardwired a*b*c responder for the init/done handshake: reads operands,
// multiplies with a reused shift-add unit, writes the 2W-bit product big-endian.
module prod3_engine
    import prod3_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int AW     = AW_DEF,
    parameter int A_ADDR = A_ADDR_DEF,
    parameter int P_ADDR = P_ADDR_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    output logic          done,
    output logic [15:0]   cycle_ct,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rd_data,
    output logic          mem_wr_en,
    output logic [W-1:0]  mem_wr_data
);

    localparam int PW  = 2 * W;
    localparam int PHW = $clog2(W);

    state_t         state_reg, state_next;
    logic           init_q_reg;
    logic [15:0]    cycle_ct_reg;
    logic [W-1:0]   a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;
    logic [W-1:0]   c_reg, c_next;
    logic [PHW-1:0] phase_reg, phase_next;

    logic           mul_start;
    logic           mul_clr;
    logic [PW-1:0]  mul_mcand;
    logic [W-1:0]   mul_mplier;
    logic           mul_busy;
    logic [PW-1:0]  mul_product;

    shift_add_mul #(
        .W  (W),
        .PW (PW)
    ) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .clr          (mul_clr),
        .multiplicand (mul_mcand),
        .multiplier   (mul_mplier),
        .busy         (mul_busy),
        .product      (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            init_q_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            phase_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            init_q_reg <= init;
            a_reg      <= a_next;
            b_reg      <= b_next;
            c_reg      <= c_next;
            phase_reg  <= phase_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_ct_reg <= '0;
        end else if (init) begin
            cycle_ct_reg <= '0;
        end else if (counted_state(state_reg) && (cycle_ct_reg != CT_MAX)) begin
            cycle_ct_reg <= cycle_ct_reg + 16'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        mul_start  = 1'b0;
        mul_clr    = 1'b0;
        mul_mcand  = '0;
        mul_mplier = '0;
        if ((state_reg != IDLE) && init) begin
            // Abort (or done acknowledge) always wins over sequencing.
            state_next = IDLE;
            phase_next = '0;
            mul_clr    = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (init_q_reg && !init) state_next = RD_A;
                end
                RD_A: state_next = RD_B;
                RD_B: begin
                    a_next     = mem_rd_data;
                    state_next = RD_C;
                end
                RD_C: begin
                    b_next     = mem_rd_data;
                    state_next = RD_W;
                end
                RD_W: begin
                    c_next     = mem_rd_data;
                    phase_next = '0;
                    state_next = MUL1;
                end
                MUL1: begin
                    mul_start  = (phase_reg == '0);
                    mul_mcand  = {{W{1'b0}}, a_reg};
                    mul_mplier = b_reg;
                    if (phase_reg == PHW'(W - 1)) begin
                        phase_next = '0;
                        state_next = MUL2;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
                MUL2: begin
                    // The multiplier's own output (a*b) is fed back as multiplicand.
                    mul_start  = (phase_reg == '0);
                    mul_mcand  = mul_product;
                    mul_mplier = c_reg;
                    if (phase_reg == PHW'(W - 1)) begin
                        phase_next = '0;
                        state_next = WR_HI;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
                WR_HI:   state_next = WR_LO;
                WR_LO:   state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state_reg)
            RD_A: mem_addr = AW'(A_ADDR);
            RD_B: mem_addr = AW'(A_ADDR + 1);
            RD_C: mem_addr = AW'(A_ADDR + 2);
            WR_HI: begin
                mem_addr    = AW'(P_ADDR);
                mem_wr_en   = 1'b1;
                mem_wr_data = mul_product[PW-1:W];
            end
            WR_LO: begin
                mem_addr    = AW'(P_ADDR + 1);
                mem_wr_en   = 1'b1;
                mem_wr_data = mul_product[W-1:0];
            end
            default: ;
        endcase
    end

    assign done     = (state_reg == DONE);
    assign cycle_ct = cycle_ct_reg;

endmodule

// File: tb/tb_prod3_engine.sv
// Directed and randomized bench for prod3_engine with a 256x8 sync-read memory.
module tb_prod3_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic        done;
    logic [15:0] cycle_ct;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rd_data;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_data;

    logic [7:0]  mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [7:0]  bd_data;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prod3_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init        (init),
        .done        (done),
        .cycle_ct    (cycle_ct),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        else if (bd_we) mem[bd_addr] <= bd_data;
        mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] vals [0:4];
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = 8'hA5; vals[4] = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            bd_we   = 1'b1;
            bd_addr = 8'(i + 1);
            bd_data = vals[i];
            @(posedge clk); #1;
        end
        bd_we = 1'b0;
    endtask

    task automatic pulse_init();
        init = 1'b1;
        @(posedge clk); #1;
        chk("ack_done_low", {31'd0, done}, 32'd0);
        chk("ack_ct_clear", {16'd0, cycle_ct}, 32'd0);
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int unsigned full;
        logic [15:0] p;
        int edges = 0;
        int nwr = 0;
        logic [7:0] wa [0:3];
        logic [7:0] wd [0:3];
        full = int'(a) * int'(b) * int'(c);
        p = full[15:0];
        load(a, b, c);
        pulse_init();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            edges++;
            if (mem_wr_en) begin
                if (nwr < 4) begin wa[nwr] = mem_addr; wd[nwr] = mem_wr_data; end
                nwr++;
            end
            if (done) break;
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("latency", edges, 32'd23);
        chk("cycle_ct", {16'd0, cycle_ct}, 32'd22);
        chk("n_writes", nwr, 32'd2);
        if (nwr >= 2) begin
            chk("wr0_addr", {24'd0, wa[0]}, 32'd4);
            chk("wr0_data", {24'd0, wd[0]}, {24'd0, p[15:8]});
            chk("wr1_addr", {24'd0, wa[1]}, 32'd5);
            chk("wr1_data", {24'd0, wd[1]}, {24'd0, p[7:0]});
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_wr_en) nwr++;
        end
        chk("mem_hi", {24'd0, mem[4]}, {24'd0, p[15:8]});
        chk("mem_lo", {24'd0, mem[5]}, {24'd0, p[7:0]});
        chk("ct_frozen", {16'd0, cycle_ct}, 32'd22);
        chk("done_held", {31'd0, done}, 32'd1);
        chk("no_extra_wr", nwr, 32'd2);
        $display("run a=%0d b=%0d c=%0d expect=%04h mem=%02h%02h ct=%0d", a, b, c, p,
                 mem[4], mem[5], cycle_ct);
    endtask

    initial begin
        int nwr;
        rst_n = 1'b0;
        init  = 1'b0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ct", {16'd0, cycle_ct}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wren", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wr_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run(8'd5, 8'd15, 8'd2);
        run(8'd12, 8'd3, 8'd4);
        run(8'd255, 8'd255, 8'd255);
        run(8'd0, 8'd200, 8'd9);

        // Abort on counted cycle 10 (inside MUL1).
        load(8'd7, 8'd9, 8'd11);
        pulse_init();
        nwr = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (mem_wr_en) nwr++;
        end
        init = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (mem_wr_en) nwr++;
        end
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ct", {16'd0, cycle_ct}, 32'd0);
        chk("abort_addr", {24'd0, mem_addr}, 32'd0);
        chk("abort_nwr", nwr, 32'd0);
        chk("abort_mem", {24'd0, mem[5]}, 32'h0000_00A5);
        $display("abort in MUL1 writes=%0d done=%0d ct=%0d", nwr, done, cycle_ct);
        init = 1'b0;
        @(posedge clk); #1;
        run(8'd7, 8'd9, 8'd11);

        // Reset during MUL2, released with init low.
        load(8'd200, 8'd100, 8'd3);
        pulse_init();
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_ct", {16'd0, cycle_ct}, 32'd0);
        chk("mrst_addr", {24'd0, mem_addr}, 32'd0);
        chk("mrst_wren", {31'd0, mem_wr_en}, 32'd0);
        chk("mrst_wdata", {24'd0, mem_wr_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nwr = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (mem_wr_en || done) nwr++;
        end
        chk("post_rst_idle", nwr, 32'd0);
        chk("post_rst_ct", {16'd0, cycle_ct}, 32'd0);
        chk("post_rst_mem", {24'd0, mem[4]}, 32'h0000_00A5);
        $display("reset in MUL2 activity=%0d ct=%0d", nwr, cycle_ct);
        run(8'd200, 8'd100, 8'd3);

        for (int r = 0; r < 6; r++) begin
            run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
